// File: rtl/raycast_pkg.sv
// Shared types and widths for the raycaster front end (dispatcher and process elements).
package raycast_pkg;

   localparam int COL_W    = 10;
   localparam int ANGLE_W  = 16;
   localparam int POS_W    = 16;
   localparam int SCREEN_W = 800;
   localparam int SCREEN_H = 600;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      SETUP,
      FIRE,
      DRAIN,
      FIN
   } dispatch_state_t;

   // Index width that stays legal for a single-element array.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_free_picker.sv
// Lowest-index free process element; a PE finishing this cycle already counts as free.
module pe_free_picker
   import raycast_pkg::*;
#(
   parameter int NUM_PE = 4,
   parameter int IDX_W  = idx_w(NUM_PE)
) (
   input  logic [NUM_PE-1:0] pe_busy,
   input  logic [NUM_PE-1:0] pe_done,
   output logic              valid,
   output logic [IDX_W-1:0]  index
);

   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = NUM_PE - 1; i >= 0; i--) begin
         if (!pe_busy[i] || pe_done[i]) begin
            valid = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/ray_dispatcher.sv
// Frame initiator: walks screen columns, hands each column's ray angle to a free PE,
// and signals frame_done once every issued column has come back.
module ray_dispatcher
   import raycast_pkg::*;
#(
   parameter int          NUM_PE       = 4,
   parameter int          SCREEN_WIDTH = 800,
   parameter logic [15:0] ANGLE_STEP   = 16'h0014,
   parameter logic [15:0] FOV_HALF     = 16'h1000,
   parameter int          SETUP_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        frame_start,
   input  logic [POS_W-1:0]            player_x,
   input  logic [POS_W-1:0]            player_y,
   input  logic [ANGLE_W-1:0]          player_angle,
   input  logic [NUM_PE-1:0]           pe_done,
   output logic [NUM_PE-1:0]           pe_start,
   output logic [NUM_PE*COL_W-1:0]     pe_column_id,
   output logic [NUM_PE*ANGLE_W-1:0]   pe_angle,
   output logic [POS_W-1:0]            pe_x_pos,
   output logic [POS_W-1:0]            pe_y_pos,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int               IDX_W      = idx_w(NUM_PE);
   localparam logic [COL_W-1:0] LAST_COL   = COL_W'(SCREEN_WIDTH - 1);
   localparam logic [7:0]       SETUP_LAST = 8'(SETUP_CYCLES - 1);

   dispatch_state_t                    state;
   logic [COL_W-1:0]                   col;
   logic [ANGLE_W-1:0]                 angle_acc;
   logic [IDX_W-1:0]                   sel;
   logic [7:0]                         setup_cnt;
   logic [NUM_PE-1:0]                  pe_busy;
   logic [NUM_PE-1:0][COL_W-1:0]       col_q;
   logic [NUM_PE-1:0][ANGLE_W-1:0]     ang_q;
   logic                               pick_valid;
   logic [IDX_W-1:0]                   pick_idx;
   logic [NUM_PE-1:0]                  fire_mask;
   logic                               accept;

   pe_free_picker #(.NUM_PE(NUM_PE), .IDX_W(IDX_W)) u_picker (
      .pe_busy (pe_busy),
      .pe_done (pe_done),
      .valid   (pick_valid),
      .index   (pick_idx)
   );

   assign fire_mask    = (state == FIRE) ? (NUM_PE'(1) << sel) : '0;
   // FIN has already dropped busy, so a new frame may start there too.
   assign accept       = frame_start && (state == IDLE || state == FIN);
   assign pe_column_id = col_q;
   assign pe_angle     = ang_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         col        <= '0;
         angle_acc  <= '0;
         sel        <= '0;
         setup_cnt  <= '0;
         pe_busy    <= '0;
         col_q      <= '0;
         ang_q      <= '0;
         pe_start   <= '0;
         pe_x_pos   <= '0;
         pe_y_pos   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         // Completions and the new issue target different PEs, so both apply.
         pe_busy    <= (pe_busy & ~pe_done) | fire_mask;
         pe_start   <= fire_mask;
         frame_done <= 1'b0;
         case (state)
            IDLE, FIN: begin
               if (accept) begin
                  pe_x_pos  <= player_x;
                  pe_y_pos  <= player_y;
                  angle_acc <= player_angle - FOV_HALF;
                  col       <= '0;
                  busy      <= 1'b1;
                  state     <= SELECT;
               end else begin
                  state <= IDLE;
               end
            end
            SELECT: begin
               if (pick_valid) begin
                  col_q[pick_idx] <= col;
                  ang_q[pick_idx] <= angle_acc;
                  sel             <= pick_idx;
                  setup_cnt       <= '0;
                  state           <= (SETUP_CYCLES == 0) ? FIRE : SETUP;
               end
            end
            SETUP: begin
               if (setup_cnt == SETUP_LAST) state <= FIRE;
               else setup_cnt <= setup_cnt + 8'd1;
            end
            FIRE: begin
               angle_acc <= angle_acc + ANGLE_STEP;
               if (col == LAST_COL) begin
                  state <= DRAIN;
               end else begin
                  col   <= col + 1'b1;
                  state <= SELECT;
               end
            end
            DRAIN: begin
               if ((pe_busy & ~pe_done) == '0) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= FIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher: two modelled PEs, a four-column screen.
module tb_ray_dispatcher;

   logic         clk;
   logic         rst_n;
   logic         frame_start;
   logic [15:0]  player_x, player_y, player_angle;
   logic [1:0]   pe_done, done_model, done_man;
   logic [1:0]   pe_start;
   logic [19:0]  pe_column_id;
   logic [31:0]  pe_angle;
   logic [15:0]  pe_x_pos, pe_y_pos;
   logic         busy, frame_done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pe_delay = 10;
   int cnt[2] = '{0, 0};
   int done_cnt = 0;
   int done_q[$];
   int fd_cnt = 0;
   int fd_dones = 0;
   int q_pe[$];
   int q_lat[$];
   int q_cyc[$];
   logic [9:0]  q_col[$];
   logic [15:0] q_ang[$];
   logic [15:0] prev_ang[2] = '{16'h0, 16'h0};
   int chg_cyc[2] = '{0, 0};

   logic [15:0] exp_ang1[4] = '{16'h0E00, 16'h0F00, 16'h1000, 16'h1100};
   logic [15:0] exp_ang2[4] = '{16'hFF00, 16'h0000, 16'h0100, 16'h0200};

   assign pe_done = done_model | done_man;

   ray_dispatcher #(
      .NUM_PE(2), .SCREEN_WIDTH(4), .ANGLE_STEP(16'h0100),
      .FOV_HALF(16'h0200), .SETUP_CYCLES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .player_x(player_x), .player_y(player_y), .player_angle(player_angle),
      .pe_done(pe_done), .pe_start(pe_start), .pe_column_id(pe_column_id),
      .pe_angle(pe_angle), .pe_x_pos(pe_x_pos), .pe_y_pos(pe_y_pos),
      .busy(busy), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // PE model: done pulses pe_delay cycles after a start.
   always @(negedge clk) begin
      done_model = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (pe_start[i]) cnt[i] = pe_delay;
         else if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
               done_model[i] = 1'b1;
               done_cnt++;
               done_q.push_back(cyc);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [15:0] a;
      for (int i = 0; i < 2; i++) begin
         a = pe_angle[16*i +: 16];
         if (a !== prev_ang[i]) begin
            chg_cyc[i] = cyc;
            prev_ang[i] = a;
         end
         if (pe_start[i]) begin
            q_pe.push_back(i);
            q_col.push_back(pe_column_id[10*i +: 10]);
            q_ang.push_back(a);
            q_lat.push_back(cyc - chg_cyc[i]);
            q_cyc.push_back(cyc);
         end
      end
      if (frame_done) begin
         fd_cnt++;
         fd_dones = done_cnt;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_frame();
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
   endtask

   task automatic wait_starts(input int n, input int budget);
      int k = 0;
      while (q_pe.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("wait_starts", q_pe.size(), n);
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (fd_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("wait_frames", fd_cnt, n);
   endtask

   task automatic chk_frame(input int base, input logic [15:0] exp_ang[4]);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pe_idx[%0d]", base + i), q_pe[base+i], i % 2);
         chk($sformatf("col[%0d]", base + i), q_col[base+i], i);
         chk($sformatf("angle[%0d]", base + i), q_ang[base+i], exp_ang[i]);
         chk($sformatf("setup_lat[%0d]", base + i), q_lat[base+i], 3);
      end
   endtask

   initial begin
      rst_n = 1'b0; frame_start = 1'b0; done_man = 2'b00;
      player_x = '0; player_y = '0; player_angle = '0;
      repeat (3) @(negedge clk);
      chk("rst_pe_start", pe_start, 0);
      chk("rst_col_id", pe_column_id, 0);
      chk("rst_angle", pe_angle, 0);
      chk("rst_xy", {pe_x_pos, pe_y_pos}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      @(negedge clk) rst_n = 1'b1;

      // Frame 1: basic issue order, angles and reuse timing
      player_x = 16'h1234; player_y = 16'h5678; player_angle = 16'h1000;
      start_frame();
      chk("f1_busy", busy, 1);
      chk("f1_x", pe_x_pos, 16'h1234);
      chk("f1_y", pe_y_pos, 16'h5678);
      wait_starts(2, 100);
      player_x = 16'hDEAD; player_angle = 16'h7777;
      start_frame();
      chk("f1_ignore_x", pe_x_pos, 16'h1234);
      chk("f1_ignore_busy", busy, 1);
      wait_frames(1, 300);
      chk("f1_starts", q_pe.size(), 4);
      if (q_pe.size() >= 4) begin
         chk_frame(0, exp_ang1);
         chk("f1_reuse", q_cyc[2] - done_q[0], 4);
      end
      chk("f1_done_after_4th", fd_dones, 4);
      @(negedge clk);
      chk("f1_busy_end", busy, 0);
      chk("f1_hold_col0", pe_column_id[9:0], 2);
      chk("f1_hold_col1", pe_column_id[19:10], 3);

      // Spurious completions on idle PEs
      @(negedge clk) done_man = 2'b11;
      @(negedge clk) done_man = 2'b00;
      repeat (3) @(negedge clk);
      chk("spur_busy", busy, 0);
      chk("spur_starts", q_pe.size(), 4);
      chk("spur_fd", fd_cnt, 1);

      // Frame 2: angle wrap, re-latched position, slow PEs stall SELECT
      pe_delay = 20;
      player_x = 16'h0AAA; player_y = 16'h0BBB; player_angle = 16'h0100;
      start_frame();
      chk("f2_x", pe_x_pos, 16'h0AAA);
      chk("f2_y", pe_y_pos, 16'h0BBB);
      wait_starts(5, 100);
      repeat (12) @(negedge clk);
      chk("f2_stall_starts", q_pe.size(), 6);
      chk("f2_hold_col", pe_column_id[9:0], 0);
      chk("f2_hold_angle", pe_angle[15:0], 16'hFF00);
      wait_frames(2, 400);
      chk("f2_starts", q_pe.size(), 8);
      if (q_pe.size() >= 8) begin
         chk_frame(4, exp_ang2);
         chk("f2_interval", q_cyc[6] - q_cyc[4], 24);
      end
      chk("f2_done_after_8th", fd_dones, 8);

      // Frame 3: reset with both PEs in flight
      player_angle = 16'h2000;
      start_frame();
      wait_starts(10, 100);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_start", pe_start, 0);
      chk("mid_rst_angle", pe_angle, 0);
      chk("mid_rst_col", pe_column_id, 0);
      chk("mid_rst_x", pe_x_pos, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_fd", fd_cnt, 2);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_starts", q_pe.size(), 10);
      chk("post_rst_frame_done", frame_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
